// File: rtl/data_sram_bridge_pkg.sv
// Shared definitions for the data-side SRAM bridge: FSM states, bus size codes,
// the watchdog abort pattern and the byte-enable to size mapping.
package data_sram_bridge_pkg;

   typedef enum logic [2:0] {
      DS_IDLE  = 3'd0,
      DS_REQ   = 3'd1,
      DS_WAIT  = 3'd2,
      DS_DONE  = 3'd3,
      DS_DRAIN = 3'd4
   } ds_state_t;

   localparam logic [1:0]  SIZE_B   = 2'd0;
   localparam logic [1:0]  SIZE_H   = 2'd1;
   localparam logic [1:0]  SIZE_W   = 2'd2;
   localparam logic [31:0] DEADBEEF = 32'hDEAD_BEEF;

   // Irregular byte-enable patterns fall back to a word access.
   function automatic logic [1:0] we_to_size(input logic [3:0] we);
      case (we)
         4'b0001, 4'b0010, 4'b0100, 4'b1000: return SIZE_B;
         4'b0011, 4'b1100:                   return SIZE_H;
         default:                            return SIZE_W;
      endcase
   endfunction

endpackage

// File: rtl/data_sram_bridge_if.sv
// SRAM-like data bus: request/address phase (req, addr_ok) and data phase (data_ok).
// master = bridge side, slave = RAM / AXI shim side.
interface data_sram_bridge_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              data_req;
   logic              data_wr;
   logic [1:0]        data_size;
   logic [ADDR_W-1:0] data_addr;
   logic [DATA_W-1:0] data_wdata;
   logic              data_addr_ok;
   logic              data_data_ok;
   logic [DATA_W-1:0] data_rdata;

   modport master (
      output data_req, data_wr, data_size, data_addr, data_wdata,
      input  data_addr_ok, data_data_ok, data_rdata
   );

   modport slave (
      input  data_req, data_wr, data_size, data_addr, data_wdata,
      output data_addr_ok, data_data_ok, data_rdata
   );
endinterface

// File: rtl/data_sram_bridge_size_dec.sv
// Combinational decode of the core's byte enables into bus size and direction.
module dsram_size_dec
   import data_sram_bridge_pkg::*;
(
   input  logic [3:0] we,
   output logic [1:0] size,
   output logic       wr
);

   always_comb begin
      size = we_to_size(we);
      wr   = |we;
   end

endmodule

// File: rtl/data_sram_bridge.sv
// Data-side bridge: turns the core's single-cycle RAM access into an SRAM-like
// transaction and stalls MEM meanwhile. Optional watchdog: define DSRAM_TIMEOUT_EN.
module data_sram_bridge
   import data_sram_bridge_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic              cpu_clk_50M,
   input  logic              cpu_rst,
   input  logic              dce,
   input  logic [ADDR_W-1:0] daddr,
   input  logic [3:0]        we,
   input  logic [DATA_W-1:0] din,
   input  logic              flush,
   output logic [DATA_W-1:0] dm,
   output logic              stallreq_mem,
   output logic              bus_err,
   data_sram_bridge_if.master bus
);

   ds_state_t  state;
   ds_state_t  state_nxt;
   logic [1:0] size_dec;
   logic       wr_dec;
   logic       addr_hs;
   logic       rd_done;
   logic       abort;

   dsram_size_dec u_size_dec (
      .we   (we),
      .size (size_dec),
      .wr   (wr_dec)
   );

   assign addr_hs = (state == DS_REQ) && bus.data_addr_ok;

   // Read data is only taken for a live (non-flushed) access whose address was accepted.
   assign rd_done = ((state == DS_WAIT) || addr_hs) && bus.data_data_ok
                    && !bus.data_wr && !flush;

   always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
      if (cpu_rst) begin
         state <= DS_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // A flush after the address was accepted must still drain the bus; a flush
   // coinciding with the final data_ok has nothing left to drain.
   always_comb begin
      state_nxt = state;
      case (state)
         DS_IDLE: begin
            if (dce && !flush) state_nxt = DS_REQ;
         end
         DS_REQ: begin
            if (bus.data_addr_ok) begin
               if (flush) state_nxt = bus.data_data_ok ? DS_IDLE : DS_DRAIN;
               else       state_nxt = bus.data_data_ok ? DS_DONE : DS_WAIT;
            end else if (flush) begin
               state_nxt = DS_IDLE;
            end
         end
         DS_WAIT: begin
            if (bus.data_data_ok) state_nxt = flush ? DS_IDLE : DS_DONE;
            else if (flush)       state_nxt = DS_DRAIN;
         end
         DS_DONE: begin
            state_nxt = DS_IDLE;
         end
         DS_DRAIN: begin
            if (bus.data_data_ok) state_nxt = DS_IDLE;
         end
         default: begin
            state_nxt = DS_IDLE;
         end
      endcase
      if (abort) state_nxt = DS_DONE;
   end

   always_comb begin
      bus.data_req = (state == DS_REQ);
      stallreq_mem = (dce && !flush && (state inside {DS_IDLE, DS_REQ, DS_WAIT}))
                     || (state == DS_DRAIN);
   end

   // Bus fields are captured once at issue and held until the access retires.
   always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
      if (cpu_rst) begin
         bus.data_wr    <= 1'b0;
         bus.data_size  <= SIZE_B;
         bus.data_addr  <= '0;
         bus.data_wdata <= '0;
         dm             <= '0;
      end else begin
         if ((state == DS_IDLE) && (state_nxt == DS_REQ)) begin
            bus.data_wr    <= wr_dec;
            bus.data_size  <= size_dec;
            bus.data_addr  <= daddr;
            bus.data_wdata <= din;
         end
         if (rd_done) begin
            dm <= bus.data_rdata;
         end else if (abort && !bus.data_wr && (state != DS_DRAIN)) begin
            dm <= DEADBEEF;
         end
      end
   end

`ifdef DSRAM_TIMEOUT_EN
   logic [7:0] wd_cnt;
   logic       busy;

   assign busy  = state inside {DS_REQ, DS_WAIT, DS_DRAIN};
   assign abort = busy && (wd_cnt == 8'(TIMEOUT - 1));

   // wd_cnt holds the number of completed cycles spent in the current state.
   always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
      if (cpu_rst) begin
         wd_cnt  <= 8'd0;
         bus_err <= 1'b0;
      end else begin
         bus_err <= abort;
         if (!busy || (state_nxt != state)) wd_cnt <= 8'd0;
         else                                wd_cnt <= wd_cnt + 8'd1;
      end
   end
`else
   assign abort   = 1'b0;
   assign bus_err = 1'b0;
`endif

endmodule

// File: tb/tb_data_sram_bridge.sv
// Directed bench for data_sram_bridge: one task per scenario, inline checks.
module tb_data_sram_bridge;

   logic        cpu_clk_50M;
   logic        cpu_rst;
   logic        dce;
   logic [31:0] daddr;
   logic [3:0]  we;
   logic [31:0] din;
   logic        flush;
   logic [31:0] dm;
   logic        stallreq_mem;
   logic        bus_err;

   int checks;
   int errors;

   logic [3:0]  we_tbl [8];
   logic [1:0]  sz_tbl [8];
   logic [31:0] exp_dm;

   data_sram_bridge_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   data_sram_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(255)) dut (
      .cpu_clk_50M  (cpu_clk_50M),
      .cpu_rst      (cpu_rst),
      .dce          (dce),
      .daddr        (daddr),
      .we           (we),
      .din          (din),
      .flush        (flush),
      .dm           (dm),
      .stallreq_mem (stallreq_mem),
      .bus_err      (bus_err),
      .bus          (bus)
   );

   initial begin
      cpu_clk_50M = 1'b0;
      forever #5 cpu_clk_50M = ~cpu_clk_50M;
   end

   task automatic issue(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
      @(negedge cpu_clk_50M);
      dce = 1'b1; flush = 1'b0; daddr = a; we = w; din = d;
      bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0;
   endtask

   task automatic retire();
      @(negedge cpu_clk_50M);
      dce = 1'b0; flush = 1'b0; we = 4'b0000;
      bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0;
   endtask

   task automatic test_reset();
      cpu_rst = 1'b1; dce = 1'b0; flush = 1'b0; daddr = '0; we = '0; din = '0;
      bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0; bus.data_rdata = '0;
      repeat (2) @(negedge cpu_clk_50M);
      #1;
      checks++; if ({bus.data_req, bus.data_wr, bus.data_size} !== 4'b0000) begin
         errors++; $display("FAIL rst_ctrl got %b exp 0000", {bus.data_req, bus.data_wr, bus.data_size}); end
      checks++; if ({bus.data_addr, bus.data_wdata} !== 64'd0) begin
         errors++; $display("FAIL rst_bus got %h exp 0", {bus.data_addr, bus.data_wdata}); end
      checks++; if ({dm, stallreq_mem, bus_err} !== 34'd0) begin
         errors++; $display("FAIL rst_out got %h exp 0", {dm, stallreq_mem, bus_err}); end
      cpu_rst = 1'b0;
   endtask

   task automatic test_word_read();
      issue(32'h0000_0100, 4'b0000, 32'h0);
      #1;
      checks++; if (stallreq_mem !== 1'b1) begin
         errors++; $display("FAIL rd_stall_idle got %b exp 1", stallreq_mem); end
      @(negedge cpu_clk_50M);
      bus.data_addr_ok = 1'b1;
      #1;
      checks++; if ({bus.data_req, bus.data_wr, bus.data_size, stallreq_mem} !== 5'b10101) begin
         errors++; $display("FAIL rd_req got %b exp 10101", {bus.data_req, bus.data_wr, bus.data_size, stallreq_mem}); end
      checks++; if (bus.data_addr !== 32'h0000_0100) begin
         errors++; $display("FAIL rd_addr got %h exp 00000100", bus.data_addr); end
      @(negedge cpu_clk_50M);
      bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b1; bus.data_rdata = 32'h1234_5678;
      #1;
      checks++; if ({bus.data_req, stallreq_mem} !== 2'b01) begin
         errors++; $display("FAIL rd_wait got %b exp 01", {bus.data_req, stallreq_mem}); end
      @(negedge cpu_clk_50M);
      bus.data_data_ok = 1'b0; bus.data_rdata = 32'h0;
      #1;
      checks++; if (stallreq_mem !== 1'b0) begin
         errors++; $display("FAIL rd_done_stall got %b exp 0", stallreq_mem); end
      checks++; if (dm !== 32'h1234_5678) begin
         errors++; $display("FAIL rd_dm got %h exp 12345678", dm); end
      retire();
      #1;
      checks++; if ({bus.data_req, stallreq_mem} !== 2'b00) begin
         errors++; $display("FAIL rd_no_reissue got %b exp 00", {bus.data_req, stallreq_mem}); end
   endtask

   task automatic test_byte_write();
      issue(32'h0000_0204, 4'b0100, 32'h00AB_0000);
      for (int i = 0; i < 4; i++) begin
         @(negedge cpu_clk_50M);
         daddr = 32'hFFFF_0000 + 32'(i);
         din   = 32'h5555_0000 + 32'(i);
         bus.data_addr_ok = (i == 3);
         #1;
         checks++; if ({bus.data_req, bus.data_wr, bus.data_size, stallreq_mem} !== 5'b11001) begin
            errors++; $display("FAIL wr_req_%0d got %b exp 11001", i, {bus.data_req, bus.data_wr, bus.data_size, stallreq_mem}); end
         checks++; if ({bus.data_addr, bus.data_wdata} !== {32'h0000_0204, 32'h00AB_0000}) begin
            errors++; $display("FAIL wr_hold_%0d got %h exp 0000020400ab0000", i, {bus.data_addr, bus.data_wdata}); end
      end
      @(negedge cpu_clk_50M);
      bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b1; bus.data_rdata = 32'hFFFF_FFFF;
      #1;
      checks++; if ({bus.data_req, stallreq_mem} !== 2'b01) begin
         errors++; $display("FAIL wr_wait got %b exp 01", {bus.data_req, stallreq_mem}); end
      @(negedge cpu_clk_50M);
      bus.data_data_ok = 1'b0;
      #1;
      checks++; if ({stallreq_mem, dm} !== {1'b0, 32'h1234_5678}) begin
         errors++; $display("FAIL wr_dm got %h exp 012345678", {stallreq_mem, dm}); end
      retire();
   endtask

   task automatic test_same_cycle();
      issue(32'h0000_0300, 4'b0000, 32'h0);
      @(negedge cpu_clk_50M);
      bus.data_addr_ok = 1'b1; bus.data_data_ok = 1'b1; bus.data_rdata = 32'hCAFE_F00D;
      #1;
      checks++; if ({bus.data_req, stallreq_mem} !== 2'b11) begin
         errors++; $display("FAIL sc_req got %b exp 11", {bus.data_req, stallreq_mem}); end
      @(negedge cpu_clk_50M);
      bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0;
      #1;
      checks++; if ({bus.data_req, stallreq_mem, dm} !== {2'b00, 32'hCAFE_F00D}) begin
         errors++; $display("FAIL sc_done got %h exp 0cafef00d", {bus.data_req, stallreq_mem, dm}); end
      retire();
   endtask

   task automatic test_flush();
      issue(32'h0000_0700, 4'b0000, 32'h0);
      @(negedge cpu_clk_50M);
      flush = 1'b1;
      #1;
      checks++; if ({bus.data_req, stallreq_mem} !== 2'b10) begin
         errors++; $display("FAIL fl_req got %b exp 10", {bus.data_req, stallreq_mem}); end
      retire();
      #1;
      checks++; if ({bus.data_req, stallreq_mem} !== 2'b00) begin
         errors++; $display("FAIL fl_req_drop got %b exp 00", {bus.data_req, stallreq_mem}); end

      issue(32'h0000_0400, 4'b0000, 32'h0);
      @(negedge cpu_clk_50M);
      bus.data_addr_ok = 1'b1;
      @(negedge cpu_clk_50M);
      bus.data_addr_ok = 1'b0; flush = 1'b1;
      @(negedge cpu_clk_50M);
      flush = 1'b0; dce = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (i == 2) begin
            @(negedge cpu_clk_50M);
            bus.data_data_ok = 1'b1; bus.data_rdata = 32'hBAD0_BAD0;
         end else if (i == 1) begin
            @(negedge cpu_clk_50M);
         end
         #1;
         checks++; if ({bus.data_req, stallreq_mem} !== 2'b01) begin
            errors++; $display("FAIL fl_drain_%0d got %b exp 01", i, {bus.data_req, stallreq_mem}); end
      end
      @(negedge cpu_clk_50M);
      bus.data_data_ok = 1'b0;
      #1;
      checks++; if ({stallreq_mem, dm} !== {1'b0, 32'hCAFE_F00D}) begin
         errors++; $display("FAIL fl_dm got %h exp 0cafef00d", {stallreq_mem, dm}); end
   endtask

   task automatic test_reset_mid();
      issue(32'h0000_0500, 4'b0001, 32'h0000_00EE);
      @(negedge cpu_clk_50M);
      bus.data_addr_ok = 1'b1;
      @(negedge cpu_clk_50M);
      bus.data_addr_ok = 1'b0; cpu_rst = 1'b1; dce = 1'b0;
      #1;
      checks++; if ({bus.data_req, bus.data_wr, bus.data_size, stallreq_mem, bus_err} !== 6'd0) begin
         errors++; $display("FAIL rm_ctrl got %b exp 000000", {bus.data_req, bus.data_wr, bus.data_size, stallreq_mem, bus_err}); end
      checks++; if ({dm, bus.data_addr, bus.data_wdata} !== 96'd0) begin
         errors++; $display("FAIL rm_data got %h exp 0", {dm, bus.data_addr, bus.data_wdata}); end
      @(negedge cpu_clk_50M);
      cpu_rst = 1'b0; bus.data_data_ok = 1'b1; bus.data_rdata = 32'h55AA_55AA;
      @(negedge cpu_clk_50M);
      bus.data_data_ok = 1'b0;
      #1;
      checks++; if ({bus.data_req, stallreq_mem, dm} !== 34'd0) begin
         errors++; $display("FAIL rm_stray got %h exp 0", {bus.data_req, stallreq_mem, dm}); end
   endtask

   task automatic test_back_to_back();
      exp_dm = 32'h0;
      for (int k = 0; k < 8; k++) begin
         issue(32'h0000_0800 + 32'(4 * k), we_tbl[k], 32'h0101_0101 * 32'(k));
         @(negedge cpu_clk_50M);
         bus.data_addr_ok = 1'b1; bus.data_data_ok = 1'b1;
         bus.data_rdata = 32'hA000_0000 | 32'(k);
         #1;
         checks++; if ({bus.data_req, bus.data_wr, bus.data_size} !== {1'b1, (we_tbl[k] != 4'b0000), sz_tbl[k]}) begin
            errors++; $display("FAIL b2b_size_%0d got %b exp %b", k, {bus.data_req, bus.data_wr, bus.data_size}, {1'b1, (we_tbl[k] != 4'b0000), sz_tbl[k]}); end
         if (we_tbl[k] == 4'b0000) exp_dm = 32'hA000_0000 | 32'(k);
         @(negedge cpu_clk_50M);
         bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0;
         #1;
         checks++; if ({stallreq_mem, dm} !== {1'b0, exp_dm}) begin
            errors++; $display("FAIL b2b_dm_%0d got %h exp %h", k, {stallreq_mem, dm}, {1'b0, exp_dm}); end
      end
      retire();
   endtask

`ifdef DSRAM_TIMEOUT_EN
   task automatic test_watchdog();
      issue(32'h0000_0900, 4'b0000, 32'h0);
      for (int i = 0; i < 255; i++) begin
         @(negedge cpu_clk_50M);
         #1;
         checks++; if ({bus.data_req, bus_err} !== 2'b10) begin
            errors++; $display("FAIL wd_wait_%0d got %b exp 10", i, {bus.data_req, bus_err}); end
      end
      @(negedge cpu_clk_50M);
      #1;
      checks++; if ({bus_err, stallreq_mem, dm} !== {2'b10, 32'hDEAD_BEEF}) begin
         errors++; $display("FAIL wd_abort got %h exp 2deadbeef", {bus_err, stallreq_mem, dm}); end
      retire();
      #1;
      checks++; if ({bus_err, bus.data_req, stallreq_mem} !== 3'b000) begin
         errors++; $display("FAIL wd_idle got %b exp 000", {bus_err, bus.data_req, stallreq_mem}); end
   endtask
`else
   task automatic test_watchdog();
      issue(32'h0000_0900, 4'b0000, 32'h0);
      for (int i = 0; i < 300; i++) begin
         @(negedge cpu_clk_50M);
         #1;
         checks++; if ({bus.data_req, stallreq_mem, bus_err} !== 3'b110) begin
            errors++; $display("FAIL wd_hold_%0d got %b exp 110", i, {bus.data_req, stallreq_mem, bus_err}); end
      end
      @(negedge cpu_clk_50M);
      bus.data_addr_ok = 1'b1; bus.data_data_ok = 1'b1; bus.data_rdata = 32'h0F0F_0F0F;
      @(negedge cpu_clk_50M);
      bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0;
      #1;
      checks++; if ({stallreq_mem, dm} !== {1'b0, 32'h0F0F_0F0F}) begin
         errors++; $display("FAIL wd_late_done got %h exp 00f0f0f0f", {stallreq_mem, dm}); end
      retire();
   endtask
`endif

   initial begin
      checks = 0;
      errors = 0;
      we_tbl[0] = 4'b0001; sz_tbl[0] = 2'd0;
      we_tbl[1] = 4'b0000; sz_tbl[1] = 2'd2;
      we_tbl[2] = 4'b0011; sz_tbl[2] = 2'd1;
      we_tbl[3] = 4'b1100; sz_tbl[3] = 2'd1;
      we_tbl[4] = 4'b1111; sz_tbl[4] = 2'd2;
      we_tbl[5] = 4'b0101; sz_tbl[5] = 2'd2;
      we_tbl[6] = 4'b0010; sz_tbl[6] = 2'd0;
      we_tbl[7] = 4'b1000; sz_tbl[7] = 2'd0;
      test_reset();
      test_word_read();
      test_byte_write();
      test_same_cycle();
      test_flush();
      test_reset_mid();
      test_back_to_back();
      test_watchdog();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
